// File: rtl/vram_draw_pkg.sv
// ============================================================================
//  Module   : vram_draw_pkg
//  Purpose  : Shared constants and types for the VRAM draw controller slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vram_draw_pkg;

    localparam int DEF_DISPLAY_WIDTH  = 240;
    localparam int DEF_DISPLAY_HEIGHT = 320;
    localparam int DEF_COLOR_W        = 16;
    localparam int DEF_BRUSH_MAX      = 3;
    localparam logic [DEF_COLOR_W-1:0] COLOR_BLACK = 16'h0000;

    localparam int VRAM_L   = DEF_DISPLAY_WIDTH * DEF_DISPLAY_HEIGHT;
    localparam int ADDR_W   = $clog2(VRAM_L);
    localparam int X_W      = $clog2(DEF_DISPLAY_WIDTH);
    localparam int Y_W      = $clog2(DEF_DISPLAY_HEIGHT);
    // One extra bit so centre+offset can go negative without wrapping.
    localparam int OFF_W    = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam int RADIUS_W = $clog2(DEF_BRUSH_MAX + 1);

    typedef logic [X_W-1:0]          coord_x_t;
    typedef logic [Y_W-1:0]          coord_y_t;
    typedef logic signed [OFF_W-1:0] brush_off_t;
    typedef logic [ADDR_W-1:0]       vram_addr_t;
    typedef logic [RADIUS_W-1:0]     radius_t;

    typedef struct packed {
        logic     valid;
        coord_x_t x;
        coord_y_t y;
    } touch_t;

    typedef enum logic [1:0] {
        S_CLEARING = 2'd0,
        S_IDLE     = 2'd1,
        S_BRUSH    = 2'd2
    } draw_state_t;

endpackage

`default_nettype wire

// File: rtl/vram_draw_controller_if.sv
// ============================================================================
//  Module   : vram_draw_controller_if
//  Purpose  : Block-RAM write port bundle between draw controller and VRAM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vram_draw_controller_if #(
    parameter int ADDR_W  = vram_draw_pkg::ADDR_W,
    parameter int COLOR_W = vram_draw_pkg::DEF_COLOR_W
);
    logic               wr_ena;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;

    modport master (output wr_ena, output wr_addr, output wr_data);
    modport slave  (input  wr_ena, input  wr_addr, input  wr_data);
endinterface

`default_nettype wire

// File: rtl/brush_scanner.sv
// ============================================================================
//  Module   : brush_scanner
//  Purpose  : Walks the (2r+1)^2 brush cells, flags clipped cells and forms
//             the linear VRAM address of the next cell to be written.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module brush_scanner
    import vram_draw_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic start,
    input  wire logic step,
    input  coord_x_t  cx_in,
    input  coord_y_t  cy_in,
    input  radius_t   radius_in,
    output logic      cell_valid,
    output vram_addr_t cell_addr,
    output logic      last
);

    coord_x_t   r_cx;
    coord_y_t   r_cy;
    radius_t    r_rad;
    brush_off_t r_dx;
    brush_off_t r_dy;
    logic       r_last;

    coord_x_t   w_cx;
    coord_y_t   w_cy;
    brush_off_t w_rad;
    brush_off_t w_dx;
    brush_off_t w_dy;
    brush_off_t w_px;
    brush_off_t w_py;
    logic       w_last;

    // Outputs describe the cell that the next clock edge will present.
    always_comb begin
        w_cx  = start ? cx_in : r_cx;
        w_cy  = start ? cy_in : r_cy;
        w_rad = brush_off_t'(start ? radius_in : r_rad);
        if (start) begin
            w_dx = -w_rad;
            w_dy = -w_rad;
        end else if (r_dx == w_rad) begin
            w_dx = -w_rad;
            w_dy = r_dy + brush_off_t'(1);
        end else begin
            w_dx = r_dx + brush_off_t'(1);
            w_dy = r_dy;
        end
        w_px   = brush_off_t'(w_cx) + w_dx;
        w_py   = brush_off_t'(w_cy) + w_dy;
        w_last = (w_dx == w_rad) && (w_dy == w_rad);
    end

    assign cell_valid = !w_px[OFF_W-1] && (w_px < brush_off_t'(DISPLAY_WIDTH)) &&
                        !w_py[OFF_W-1] && (w_py < brush_off_t'(DISPLAY_HEIGHT));
    assign cell_addr  = vram_addr_t'($unsigned(w_py)) * vram_addr_t'(DISPLAY_WIDTH) +
                        vram_addr_t'($unsigned(w_px));
    assign last       = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_rad  <= '0;
            r_dx   <= '0;
            r_dy   <= '0;
            r_last <= 1'b0;
        end else if (start || step) begin
            r_cx   <= w_cx;
            r_cy   <= w_cy;
            r_rad  <= radius_t'(w_rad);
            r_dx   <= w_dx;
            r_dy   <= w_dy;
            r_last <= w_last;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vram_draw_controller.sv
// ============================================================================
//  Module   : vram_draw_controller
//  Purpose  : VRAM write-side controller: frame clear plus clipped square
//             brush painting. Build option VRAM_DRAW_DEDUP_EN suppresses
//             repaints of an identical consecutive brush.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_draw_controller
    import vram_draw_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
    parameter int COLOR_W        = DEF_COLOR_W,
    parameter int BRUSH_MAX      = DEF_BRUSH_MAX,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_BLACK
) (
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    input  touch_t                              touch,
    input  wire logic [COLOR_W-1:0]             brush_color,
    input  wire logic [$clog2(BRUSH_MAX+1)-1:0] brush_radius,
    input  wire logic                           clear_req,
    vram_draw_controller_if.master              vram,
    output logic                                busy,
    output logic                                clear_done
);

    localparam vram_addr_t c_vram_l = vram_addr_t'(DISPLAY_WIDTH * DISPLAY_HEIGHT);

    draw_state_t        r_state;
    vram_addr_t         r_clr_cnt;
    logic               r_clr_pend;
    logic [COLOR_W-1:0] r_color;

    radius_t    w_radius;
    logic       w_touch_ok;
    logic       w_dup;
    logic       w_accept;
    logic       w_step;
    logic       w_cell_valid;
    vram_addr_t w_cell_addr;
    logic       w_last;

    assign w_radius   = (int'(brush_radius) > BRUSH_MAX) ? radius_t'(BRUSH_MAX)
                                                         : radius_t'(brush_radius);
    assign w_touch_ok = touch.valid && (int'(touch.x) < DISPLAY_WIDTH) &&
                        (int'(touch.y) < DISPLAY_HEIGHT);
    assign w_accept   = (r_state == S_IDLE) && !clear_req && w_touch_ok && !w_dup;
    assign w_step     = (r_state == S_BRUSH) && !w_last;

`ifdef VRAM_DRAW_DEDUP_EN
    logic               r_hist_vld;
    coord_x_t           r_hist_x;
    coord_y_t           r_hist_y;
    logic [COLOR_W-1:0] r_hist_color;
    radius_t            r_hist_rad;
    logic               w_clr_start;

    assign w_clr_start = ((r_state == S_IDLE) && clear_req) ||
                         ((r_state == S_BRUSH) && w_last && (r_clr_pend || clear_req));
    assign w_dup = r_hist_vld && (touch.x == r_hist_x) && (touch.y == r_hist_y) &&
                   (brush_color == r_hist_color) && (w_radius == r_hist_rad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist_vld   <= 1'b0;
            r_hist_x     <= '0;
            r_hist_y     <= '0;
            r_hist_color <= '0;
            r_hist_rad   <= '0;
        end else if (w_accept) begin
            r_hist_vld   <= 1'b1;
            r_hist_x     <= touch.x;
            r_hist_y     <= touch.y;
            r_hist_color <= brush_color;
            r_hist_rad   <= w_radius;
        end else if (w_clr_start) begin
            r_hist_vld   <= 1'b0;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    brush_scanner #(
        .DISPLAY_WIDTH  (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT (DISPLAY_HEIGHT)
    ) u_scanner (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_accept),
        .step       (w_step),
        .cx_in      (touch.x),
        .cy_in      (touch.y),
        .radius_in  (w_radius),
        .cell_valid (w_cell_valid),
        .cell_addr  (w_cell_addr),
        .last       (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CLEARING;
            r_clr_cnt    <= '0;
            r_clr_pend   <= 1'b0;
            r_color      <= CLEAR_COLOR;
            vram.wr_ena  <= 1'b0;
            vram.wr_addr <= '0;
            vram.wr_data <= CLEAR_COLOR;
            busy         <= 1'b1;
            clear_done   <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (r_state)
                S_CLEARING: begin
                    r_clr_pend <= 1'b0;
                    if (r_clr_cnt == c_vram_l) begin
                        vram.wr_ena <= 1'b0;
                        clear_done  <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        vram.wr_ena  <= 1'b1;
                        vram.wr_addr <= r_clr_cnt;
                        vram.wr_data <= CLEAR_COLOR;
                        r_clr_cnt    <= r_clr_cnt + vram_addr_t'(1);
                    end
                end
                S_IDLE: begin
                    vram.wr_ena <= 1'b0;
                    busy        <= 1'b0;
                    if (clear_req) begin
                        r_state    <= S_CLEARING;
                        r_clr_cnt  <= '0;
                        r_clr_pend <= 1'b0;
                        busy       <= 1'b1;
                    end else if (w_accept) begin
                        // First cell is registered here so it shows one cycle after acceptance.
                        r_state      <= S_BRUSH;
                        r_color      <= brush_color;
                        busy         <= 1'b1;
                        vram.wr_ena  <= w_cell_valid;
                        vram.wr_addr <= w_cell_addr;
                        vram.wr_data <= brush_color;
                    end
                end
                S_BRUSH: begin
                    if (!w_last) begin
                        vram.wr_ena  <= w_cell_valid;
                        vram.wr_addr <= w_cell_addr;
                        vram.wr_data <= r_color;
                        if (clear_req) begin
                            r_clr_pend <= 1'b1;
                        end
                    end else begin
                        vram.wr_ena <= 1'b0;
                        if (r_clr_pend || clear_req) begin
                            r_state    <= S_CLEARING;
                            r_clr_cnt  <= '0;
                            r_clr_pend <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state   <= S_CLEARING;
                    r_clr_cnt <= '0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vram_draw_controller.sv
// ============================================================================
//  Module   : tb_vram_draw_controller
//  Purpose  : Directed self-checking bench for vram_draw_controller on a
//             240x20 frame (same row pitch as the panel, shorter clears).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_draw_controller;
    import vram_draw_pkg::*;

    localparam int          c_w     = 240;
    localparam int          c_h     = 20;
    localparam int          c_l     = c_w * c_h;
    localparam logic [15:0] c_black = 16'h0000;
    localparam logic [15:0] c_red   = 16'hF800;
    localparam logic [15:0] c_green = 16'h07E0;

    logic        clk;
    logic        rst_n;
    touch_t      touch;
    logic [15:0] brush_color;
    logic [1:0]  brush_radius;
    logic        clear_req;
    logic        busy;
    logic        clear_done;

    int n_checks = 0;
    int n_fails  = 0;
    int wr_q[$];

    vram_draw_controller_if vif ();

    vram_draw_controller #(
        .DISPLAY_WIDTH  (c_w),
        .DISPLAY_HEIGHT (c_h)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .touch        (touch),
        .brush_color  (brush_color),
        .brush_radius (brush_radius),
        .clear_req    (clear_req),
        .vram         (vif),
        .busy         (busy),
        .clear_done   (clear_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Runs from the current negedge until clear_done; optionally pulses clear_req mid-clear.
    task automatic run_clear(input string tag, input int pulse_at);
        int nwr  = 0;
        int bad  = 0;
        int seen = 0;
        for (int cyc = 0; cyc < c_l + 50; cyc++) begin
            clear_req = 1'b0;
            if (vif.wr_ena) begin
                if (vif.wr_addr != nwr[16:0] || vif.wr_data != c_black || !busy) bad++;
                if (nwr == pulse_at) clear_req = 1'b1;
                nwr++;
            end
            if (clear_done) begin
                seen = 1;
                check_eq({tag, "_ena_at_done"}, int'(vif.wr_ena), 0);
                break;
            end
            @(negedge clk);
        end
        clear_req = 1'b0;
        check_eq({tag, "_done_seen"}, seen, 1);
        check_eq({tag, "_writes"}, nwr, c_l);
        check_eq({tag, "_order"}, bad, 0);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, int'(clear_done), 0);
    endtask

    // Presents one touch for a single clock, then records writes while busy (up to max_cyc).
    task automatic do_brush(input int x, input int y, input int r, input logic [15:0] col,
                            input int clr_at, input int max_cyc,
                            output int ncyc, output int bad);
        wr_q.delete();
        ncyc = 0;
        bad  = 0;
        touch.valid  = 1'b1;
        touch.x      = coord_x_t'(x);
        touch.y      = coord_y_t'(y);
        brush_color  = col;
        brush_radius = 2'(r);
        @(negedge clk);
        touch.valid = 1'b0;
        while (busy && ncyc < max_cyc) begin
            clear_req = (ncyc == clr_at);
            if (vif.wr_ena) begin
                wr_q.push_back(int'(vif.wr_addr));
                if (vif.wr_data != col) bad++;
            end
            ncyc++;
            @(negedge clk);
        end
        clear_req = 1'b0;
    endtask

    initial begin
        int ncyc;
        int bad;
        int exp3[9] = '{0, 1, 2, 240, 241, 242, 480, 481, 482};
        int exp4[4] = '{4558, 4559, 4798, 4799};
        int hit;

        rst_n        = 1'b0;
        touch        = '0;
        brush_color  = '0;
        brush_radius = '0;
        clear_req    = 1'b0;

        // Reset state and initial frame clear
        @(negedge clk);
        check_eq("rst_ena",  int'(vif.wr_ena), 0);
        check_eq("rst_addr", int'(vif.wr_addr), 0);
        check_eq("rst_data", int'(vif.wr_data), int'(c_black));
        check_eq("rst_busy", int'(busy), 1);
        check_eq("rst_done", int'(clear_done), 0);
        rst_n = 1'b1;
        run_clear("clr0", -1);

        // Single-pixel brush
        do_brush(100, 10, 0, c_red, -1, 60, ncyc, bad);
        check_eq("r0_cycles", ncyc, 1);
        check_eq("r0_writes", wr_q.size(), 1);
        check_eq("r0_addr", (wr_q.size() > 0) ? wr_q[0] : -1, 2500);
        check_eq("r0_data", bad, 0);

        // Top-left corner clip, r=2
        do_brush(0, 0, 2, c_green, -1, 60, ncyc, bad);
        check_eq("tl_cycles", ncyc, 25);
        check_eq("tl_writes", wr_q.size(), 9);
        for (int i = 0; i < 9; i++)
            check_eq($sformatf("tl_addr%0d", i), (i < wr_q.size()) ? wr_q[i] : -1, exp3[i]);
        check_eq("tl_data", bad, 0);

        // Bottom-right corner clip, r=1
        do_brush(239, 19, 1, c_red, -1, 60, ncyc, bad);
        check_eq("br_cycles", ncyc, 9);
        check_eq("br_writes", wr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("br_addr%0d", i), (i < wr_q.size()) ? wr_q[i] : -1, exp4[i]);

        // Out-of-range touches are ignored
        do_brush(240, 10, 0, c_red, -1, 60, ncyc, bad);
        check_eq("oor_x_cycles", ncyc, 0);
        check_eq("oor_x_ena", int'(vif.wr_ena), 0);
        do_brush(5, 20, 0, c_red, -1, 60, ncyc, bad);
        check_eq("oor_y_cycles", ncyc, 0);

        // clear_req mid-brush: brush completes, then a full clear
        do_brush(50, 10, 3, c_red, 10, 49, ncyc, bad);
        check_eq("mid_cycles", ncyc, 49);
        check_eq("mid_writes", wr_q.size(), 49);
        check_eq("mid_first", (wr_q.size() > 0) ? wr_q[0] : -1, 1727);
        check_eq("mid_last", (wr_q.size() > 0) ? wr_q[wr_q.size()-1] : -1, 3173);
        check_eq("mid_data", bad, 0);
        check_eq("mid_gap_ena", int'(vif.wr_ena), 0);
        check_eq("mid_gap_busy", int'(busy), 1);
        run_clear("clr1", -1);

        // Reset mid-clear at address 1000; clear restarts from 0 and ignores a late clear_req
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        hit = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (vif.wr_ena && vif.wr_addr == 17'd1000) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        check_eq("mrst_reached_1000", hit, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_ena",  int'(vif.wr_ena), 0);
        check_eq("mrst_addr", int'(vif.wr_addr), 0);
        check_eq("mrst_busy", int'(busy), 1);
        check_eq("mrst_done", int'(clear_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_clear("clr2", 300);

        // Identical touch twice in a row
        do_brush(100, 10, 0, c_red, -1, 60, ncyc, bad);
        check_eq("rep1_writes", wr_q.size(), 1);
        do_brush(100, 10, 0, c_red, -1, 60, ncyc, bad);
`ifdef VRAM_DRAW_DEDUP_EN
        check_eq("rep2_writes", wr_q.size(), 0);
`else
        check_eq("rep2_writes", wr_q.size(), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
